// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I-subset core.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_HALT
  } state_e;

  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_LUI = 7'h37;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_e;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_A, SRCA_ZERO} srca_e;
  typedef enum logic [1:0] {SRCB_B, SRCB_IMM, SRCB_FOUR} srcb_e;
  typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALU} res_src_e;

  function automatic logic [31:0] build_imm(input logic [31:0] ins, input imm_src_e src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_controller.sv
// FSM sequencer plus instruction legality, ALU-control and immediate-type decode.
module mc_controller
  import riscv_pkg::*;
#(
  parameter int RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        data_write,
  output logic        ab_write,
  output logic        aluout_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        instret_inc,
  output logic        halted,
  output res_src_e    result_src,
  output srca_e       alu_src_a,
  output srcb_e       alu_src_b,
  output alu_ctrl_e   alu_ctrl,
  output imm_src_e    imm_src
);

  localparam logic [4:0] IDX_MASK = 5'(RF_DEPTH - 1);

  state_e state_q, state_d;
  state_e dec_next;
  logic   legal;
  alu_ctrl_e exec_ctrl;
  imm_src_e  dec_imm;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign op  = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  // Depth is a power of two, so any set bit above the mask is an out-of-range index.
  function automatic logic reg_ok(input logic [4:0] r);
    return ((r & ~IDX_MASK) == 5'd0);
  endfunction

  always_comb begin
    legal    = 1'b0;
    dec_next = S_HALT;
    case (op)
      OP_LW: begin
        legal    = (f3 == 3'b010) && reg_ok(rd) && reg_ok(rs1);
        dec_next = S_MEMADR;
      end
      OP_SW: begin
        legal    = (f3 == 3'b010) && reg_ok(rs1) && reg_ok(rs2);
        dec_next = S_MEMADR;
      end
      OP_R: begin
        legal    = ((f7 == 7'h00 && (f3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                    (f7 == 7'h20 && f3 == 3'b000)) &&
                   reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
        dec_next = S_EXECR;
      end
      OP_I: begin
        legal    = (f3 inside {3'b000, 3'b111, 3'b110, 3'b010}) && reg_ok(rd) && reg_ok(rs1);
        dec_next = S_EXECI;
      end
      OP_LUI: begin
        legal    = reg_ok(rd);
        dec_next = S_EXECI;
      end
      OP_BR: begin
        legal    = (f3 inside {3'b000, 3'b001}) && reg_ok(rs1) && reg_ok(rs2);
        dec_next = S_BRANCH;
      end
      OP_JAL: begin
        legal    = reg_ok(rd);
        dec_next = S_JAL;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) dec_next = S_HALT;
  end

  always_comb begin
    exec_ctrl = ALU_ADD;
    if (op != OP_LUI) begin
      case (f3)
        3'b000:  exec_ctrl = (op == OP_R && f7[5]) ? ALU_SUB : ALU_ADD;
        3'b111:  exec_ctrl = ALU_AND;
        3'b110:  exec_ctrl = ALU_OR;
        3'b010:  exec_ctrl = ALU_SLT;
        default: exec_ctrl = ALU_ADD;
      endcase
    end
    case (op)
      OP_SW:   dec_imm = IMM_S;
      OP_BR:   dec_imm = IMM_B;
      OP_JAL:  dec_imm = IMM_J;
      OP_LUI:  dec_imm = IMM_U;
      default: dec_imm = IMM_I;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    data_write   = 1'b0;
    ab_write     = 1'b0;
    aluout_write = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    instret_inc  = 1'b0;
    halted       = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_FOUR;
    alu_ctrl     = ALU_ADD;
    imm_src      = dec_imm;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      // Branch/jump target is formed here so BRANCH/JAL only need to select it.
      S_DECODE: begin
        ab_write     = 1'b1;
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
        state_d      = dec_next;
      end
      S_MEMADR: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
        state_d      = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          data_write = 1'b1;
          state_d    = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write   = 1'b1;
        result_src  = RES_DATA;
        instret_inc = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instret_inc = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_B;
        alu_ctrl     = exec_ctrl;
        aluout_write = 1'b1;
        state_d      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a    = (op == OP_LUI) ? SRCA_ZERO : SRCA_A;
        alu_src_b    = SRCB_IMM;
        alu_ctrl     = exec_ctrl;
        aluout_write = 1'b1;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write   = 1'b1;
        instret_inc = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_B;
        alu_ctrl    = ALU_SUB;
        pc_src      = 1'b1;
        pc_write    = (f3 == 3'b000) ? zero : !zero;
        instret_inc = 1'b1;
        state_d     = S_FETCH;
      end
      // Link value OldPC+4 comes straight off the ALU while PC takes the stored target.
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        reg_write   = 1'b1;
        result_src  = RES_ALU;
        pc_write    = 1'b1;
        pc_src      = 1'b1;
        instret_inc = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core: datapath, register file and ALU around mc_controller.
module riscv_multicycle
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic [31:0] PC,
  output logic [31:0] InstRet,
  output logic        Halted
);

  localparam int IDX_W = $clog2(RF_DEPTH);

  logic [31:0] pc_q, pc_d, instret_q, instret_d;
  logic [31:0] instr_q, instr_d, oldpc_q, oldpc_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, data_q, data_d;
  logic [31:0] rf_q [RF_DEPTH];

  logic        mem_req, mem_write, adr_src, ir_write, data_write, ab_write;
  logic        aluout_write, pc_write, pc_src, reg_write, instret_inc, halted;
  res_src_e    result_src;
  srca_e       alu_src_a;
  srcb_e       alu_src_b;
  alu_ctrl_e   alu_ctrl;
  imm_src_e    imm_src;

  logic [IDX_W-1:0] ra1, ra2, wa;
  logic [31:0] rd1, rd2, imm, src_a, src_b, alu_res, result;
  logic signed [31:0] sa, sb;
  logic        zero, rf_we;

  mc_controller #(.RF_DEPTH(RF_DEPTH)) u_ctrl (
    .clk          (clk),
    .rst_n        (reset),
    .instr        (instr_q),
    .zero         (zero),
    .mem_ready    (MemReady),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .data_write   (data_write),
    .ab_write     (ab_write),
    .aluout_write (aluout_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .instret_inc  (instret_inc),
    .halted       (halted),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .imm_src      (imm_src)
  );

  assign ra1 = instr_q[15 +: IDX_W];
  assign ra2 = instr_q[20 +: IDX_W];
  assign wa  = instr_q[7 +: IDX_W];
  assign rd1 = (ra1 == '0) ? 32'd0 : rf_q[ra1];
  assign rd2 = (ra2 == '0) ? 32'd0 : rf_q[ra2];
  assign imm = build_imm(instr_q, imm_src);

  always_comb begin
    case (alu_src_a)
      SRCA_PC:    src_a = pc_q;
      SRCA_OLDPC: src_a = oldpc_q;
      SRCA_A:     src_a = a_q;
      default:    src_a = 32'd0;
    endcase
    case (alu_src_b)
      SRCB_B:   src_b = b_q;
      SRCB_IMM: src_b = imm;
      default:  src_b = 32'd4;
    endcase
    sa = src_a;
    sb = src_b;
    case (alu_ctrl)
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = {31'd0, (sa < sb)};
      default: alu_res = src_a + src_b;
    endcase
    zero = (alu_res == 32'd0);
    case (result_src)
      RES_DATA: result = data_q;
      RES_ALU:  result = alu_res;
      default:  result = aluout_q;
    endcase
    rf_we = reg_write && (wa != '0);
  end

  always_comb begin
    pc_d      = pc_q;
    if (pc_write) pc_d = pc_src ? aluout_q : alu_res;
    instret_d = instret_q + 32'(instret_inc);
    instr_d   = ir_write     ? MemRData : instr_q;
    oldpc_d   = ir_write     ? pc_q     : oldpc_q;
    a_d       = ab_write     ? rd1      : a_q;
    b_d       = ab_write     ? rd2      : b_q;
    aluout_d  = aluout_write ? alu_res  : aluout_q;
    data_d    = data_write   ? MemRData : data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_q  <= instr_d;
    oldpc_q  <= oldpc_d;
    a_q      <= a_d;
    b_q      <= b_d;
    aluout_q <= aluout_d;
    data_q   <= data_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= 32'd0;
    end else if (rf_we) begin
      rf_q[wa] <= result;
    end
  end

  // Bus outputs are forced low combinationally so reset drops a pending request at once.
  assign MemReq   = reset & mem_req;
  assign MemWrite = reset & mem_write;
  assign MemAddr  = reset ? (adr_src ? aluout_q : pc_q) : 32'd0;
  assign MemWData = reset ? b_q : 32'd0;
  assign PC       = pc_q;
  assign InstRet  = instret_q;
  assign Halted   = halted;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: ALU vector table plus multi-cycle corner sequences.
module tb_riscv_multicycle;

  localparam logic [6:0] T_LW = 7'h03, T_I = 7'h13, T_LUI = 7'h37;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset;
  logic        MemReq, MemWrite, MemReady;
  logic [31:0] MemAddr, MemWData, MemRData, PC, InstRet;
  logic        Halted;

  logic [31:0] mem [256];
  logic [31:0] stall_addr;
  int          stall_n, stall_cnt;
  int          st_count;
  logic [31:0] st_addr, st_data;
  int          checks, errors, cyc, base;

  typedef struct {
    logic [31:0] i0, i1, i2;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [12];

  riscv_multicycle #(.RESET_PC(32'h100), .RF_DEPTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemReq   (MemReq),
    .MemWrite (MemWrite),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRData (MemRData),
    .MemReady (MemReady),
    .PC       (PC),
    .InstRet  (InstRet),
    .Halted   (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reads are combinational, stores are logged, stalls target one address.
  always_comb begin
    MemRData = mem[MemAddr[9:2]];
    MemReady = !(MemReq && MemAddr == stall_addr && stall_cnt < stall_n);
  end

  initial begin
    stall_cnt = 0;
    st_count  = 0;
    st_addr   = 32'd0;
    st_data   = 32'd0;
  end

  always @(posedge clk) begin
    if (MemReq && MemAddr == stall_addr) stall_cnt <= MemReady ? stall_cnt : stall_cnt + 1;
    else stall_cnt <= 0;
    if (MemReq && MemReady && MemWrite) begin
      st_count <= st_count + 1;
      st_addr  <= MemAddr;
      st_data  <= MemWData;
    end
  end

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    base  = st_count;
  endtask

  task automatic wait_store(input int limit);
    while (st_count == base && cyc < limit) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    base   = 0;
    reset  = 1'b0;
    stall_addr = 32'hFFFF_FFFF;
    stall_n    = 0;

    vt[0]  = '{enc_i(5, 0, 0, 1, T_I), enc_i(7, 0, 0, 2, T_I), enc_r(0, 2, 1, 0, 3), 32'd12};
    vt[1]  = '{enc_i(5, 0, 0, 1, T_I), enc_i(7, 0, 0, 2, T_I), enc_r(32, 2, 1, 0, 3), 32'hFFFF_FFFE};
    vt[2]  = '{enc_i(-1, 0, 0, 1, T_I), enc_i(240, 0, 0, 2, T_I), enc_r(0, 2, 1, 7, 3), 32'h0000_00F0};
    vt[3]  = '{enc_i(32'h500, 0, 0, 1, T_I), enc_i(10, 1, 6, 3, T_I), NOP, 32'h0000_050A};
    vt[4]  = '{enc_i(-3, 0, 0, 1, T_I), enc_i(2, 0, 0, 2, T_I), enc_r(0, 2, 1, 2, 3), 32'd1};
    vt[5]  = '{enc_i(2, 0, 0, 1, T_I), enc_i(-3, 1, 2, 3, T_I), NOP, 32'd0};
    vt[6]  = '{enc_i(-1, 0, 0, 1, T_I), enc_i(32'h7FF, 1, 7, 3, T_I), NOP, 32'h0000_07FF};
    vt[7]  = '{{20'hABCDE, 5'd3, T_LUI}, NOP, NOP, 32'hABCD_E000};
    vt[8]  = '{enc_i(1, 0, 0, 0, T_I), enc_r(0, 0, 0, 0, 3), NOP, 32'd0};
    vt[9]  = '{{20'h80000, 5'd1, T_LUI}, enc_i(-1, 0, 0, 2, T_I), enc_r(0, 2, 1, 0, 3), 32'h7FFF_FFFF};
    vt[10] = '{enc_i(32'h123, 0, 0, 1, T_I), enc_i(32'h450, 0, 0, 2, T_I), enc_r(0, 2, 1, 6, 3), 32'h0000_0573};
    vt[11] = '{enc_i(5, 0, 0, 1, T_I), enc_i(-1, 0, 0, 2, T_I), enc_r(0, 2, 1, 2, 3), 32'd0};

    // Reset state and first fetch
    hold_reset();
    repeat (2) @(negedge clk);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_wdata", MemWData, 32'd0);
    chk("rst_pc", PC, 32'h100);
    chk("rst_instret", InstRet, 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    release_reset();
    #1;
    chk("first_req", 32'(MemReq), 32'd1);
    chk("first_addr", MemAddr, 32'h100);

    // ALU / immediate vectors, each followed by sw x3,64(x0)
    for (int k = 0; k < 12; k++) begin
      hold_reset();
      mem[64] = vt[k].i0;
      mem[65] = vt[k].i1;
      mem[66] = vt[k].i2;
      mem[67] = enc_s(64, 3, 0);
      release_reset();
      wait_store(100);
      chk($sformatf("v%0d_data", k), st_data, vt[k].exp);
      chk($sformatf("v%0d_addr", k), st_addr, 32'd64);
      chk($sformatf("v%0d_cycles", k), 32'(cyc), 32'd16);
      chk($sformatf("v%0d_instret", k), InstRet, 32'd4);
    end

    // lw with three wait states on the data access
    hold_reset();
    mem[64] = enc_i(32'h80, 0, 2, 3, T_LW);
    mem[65] = enc_s(64, 3, 0);
    mem[32] = 32'hDEAD_BEEF;
    stall_addr = 32'h80;
    stall_n    = 3;
    release_reset();
    repeat (3) step();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("lw_hold_addr%0d", j), MemAddr, 32'h80);
      chk($sformatf("lw_hold_ctl%0d", j), 32'({MemReq, MemWrite, MemReady}), 32'b100);
      step();
    end
    step();
    chk("lw_instret_c7", InstRet, 32'd0);
    step();
    chk("lw_instret_c8", InstRet, 32'd1);
    wait_store(100);
    chk("lw_data", st_data, 32'hDEAD_BEEF);
    chk("lw_sw_cycles", 32'(cyc), 32'd12);
    stall_n = 0;

    // bne not taken, beq taken backwards
    hold_reset();
    mem[64] = enc_i(3, 0, 0, 1, T_I);
    mem[65] = enc_b(-8, 1, 1, 1);
    mem[66] = enc_b(-8, 0, 0, 0);
    release_reset();
    repeat (4) step();
    chk("br_addi_instret", InstRet, 32'd1);
    repeat (3) step();
    chk("bne_pc", PC, 32'h108);
    chk("bne_instret", InstRet, 32'd2);
    repeat (2) step();
    chk("beq_pc_fetch", PC, 32'h10C);
    chk("beq_instret_pre", InstRet, 32'd2);
    step();
    chk("beq_pc_taken", PC, 32'h100);
    chk("beq_instret", InstRet, 32'd3);

    // jal x1,16 then sw x1,64(x0) at the target
    hold_reset();
    mem[64] = enc_j(16, 1);
    mem[68] = enc_s(64, 1, 0);
    release_reset();
    wait_store(100);
    chk("jal_link", st_data, 32'h104);
    chk("jal_pc", PC, 32'h114);
    chk("jal_instret", InstRet, 32'd2);

    // Illegal opcode halts; async reset clears it
    hold_reset();
    mem[64] = enc_i(1, 0, 0, 1, T_I);
    mem[65] = 32'h0000_007F;
    release_reset();
    repeat (6) step();
    chk("halt_flag", 32'(Halted), 32'd1);
    repeat (5) step();
    chk("halt_sticky", 32'(Halted), 32'd1);
    chk("halt_noreq", 32'(MemReq), 32'd0);
    chk("halt_pc", PC, 32'h108);
    chk("halt_instret", InstRet, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("halt_async_clr", 32'(Halted), 32'd0);
    chk("halt_async_pc", PC, 32'h100);

    // Unsupported funct7 on an R-type is illegal
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
    mem[64] = enc_r(1, 2, 1, 0, 3);
    release_reset();
    repeat (2) step();
    chk("illegal_r_halt", 32'(Halted), 32'd1);

    // Reset during a stalled store: request drops, store never lands
    hold_reset();
    mem[64] = enc_i(9, 0, 0, 1, T_I);
    mem[65] = enc_s(32'h80, 1, 0);
    stall_addr = 32'h80;
    stall_n    = 20;
    release_reset();
    repeat (7) step();
    chk("st_hold_ctl", 32'({MemReq, MemWrite, MemReady}), 32'b110);
    chk("st_hold_addr", MemAddr, 32'h80);
    chk("st_hold_wdata", MemWData, 32'd9);
    step();
    chk("st_hold_ctl2", 32'({MemReq, MemWrite}), 32'b11);
    chk("st_hold_wdata2", MemWData, 32'd9);
    #2;
    reset = 1'b0;
    #1;
    chk("st_rst_req", 32'({MemReq, MemWrite}), 32'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("st_rst_nostore", 32'(st_count - base), 32'd0);
    stall_n = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
